// File: rtl/keypad_scan_encoder_if.sv
// Key-code output channel: valid/ready handshake carrying one encoded key press.
// Latency: none, this is wiring only.
// Backpressure: the master holds val/val_valid stable until val_ready is seen.
interface keypad_scan_encoder_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] val;
    logic              val_valid;
    logic              val_ready;

    modport master (
        output val,
        output val_valid,
        input  val_ready
    );

    modport slave (
        input  val,
        input  val_valid,
        output val_ready
    );
endinterface

// File: rtl/keypad_scan_encoder.sv
// Scans a NUM_ROWS x NUM_COLS switch matrix, debounces each key over whole frames, encodes new presses.
// Latency: a press is reported on the EVAL edge of the DEBOUNCE_FRAMES-th consecutive pressed frame.
// Backpressure: a pending code is held while val_ready is low; events arriving meanwhile are dropped and flagged in overflow.
module keypad_scan_encoder #(
    parameter int NUM_COLS        = 4,
    parameter int NUM_ROWS        = 3,
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int CODE_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [NUM_COLS-1:0]  col_drive,
    input  logic [NUM_ROWS-1:0]  row_sense,
    keypad_scan_encoder_if.master vo,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int NK    = NUM_ROWS * NUM_COLS;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [COL_W-1:0]    LAST_COL    = COL_W'(NUM_COLS - 1);
    localparam logic [SET_W-1:0]    LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_SAT     = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]    CNT_PRE     = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [NUM_COLS-1:0] COL_FIRST   = NUM_COLS'(1);

    typedef enum logic [1:0] {
        ST_DRIVE,
        ST_SAMPLE,
        ST_NEXT_COL,
        ST_EVAL
    } state_t;

    // Scan state
    state_t              state_q;
    logic [COL_W-1:0]    col_q;
    logic [SET_W-1:0]    settle_q;
    logic [NUM_COLS-1:0] col_drive_q;

    // Row synchronizer
    logic [NUM_ROWS-1:0] sync1_q;
    logic [NUM_ROWS-1:0] sync2_q;

    // Frame image and per-key debounce state; key index = row*NUM_COLS + col
    logic [NK-1:0]            image_q;
    logic [NK-1:0]            image_d;
    logic [NK-1:0][CNT_W-1:0] cnt_q;
    logic [NK-1:0][CNT_W-1:0] cnt_d;
    logic [NK-1:0]            acc_q;
    logic [NK-1:0]            acc_d;
    logic [NK-1:0]            ev_d;

    // Event selection and output registers
    logic [CODE_W-1:0] ev_code_d;
    logic              ev_multi_d;
    logic              ev_any_d;
    logic              load_d;
    logic              ovf_set_d;
    logic [CODE_W-1:0] val_q;
    logic              val_valid_q;
    logic              overflow_q;

    assign col_drive    = col_drive_q;
    assign vo.val       = val_q;
    assign vo.val_valid = val_valid_q;
    assign overflow     = overflow_q;

    // Two-flop synchronizer on the raw row inputs; nothing downstream sees row_sense directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= row_sense;
            sync2_q <= sync1_q;
        end
    end

    // Image with the currently driven column replaced by the synchronized rows
    always_comb begin
        image_d = image_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (COL_W'(c) == col_q) begin
                    image_d[r*NUM_COLS + c] = sync2_q[r];
                end
            end
        end
    end

    // Per-key debounce step: saturate while pressed, clear on any released frame, fire once on reaching the threshold
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ev_d  = '0;
        for (int k = 0; k < NK; k++) begin
            if (image_q[k]) begin
                if (cnt_q[k] != CNT_SAT) begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
                if (((cnt_q[k] == CNT_SAT) || (cnt_q[k] == CNT_PRE)) && !acc_q[k]) begin
                    ev_d[k]  = 1'b1;
                    acc_d[k] = 1'b1;
                end
            end else begin
                cnt_d[k] = '0;
                acc_d[k] = 1'b0;
            end
        end
    end

    // Lowest-numbered event wins the output slot
    always_comb begin
        ev_code_d = '0;
        for (int k = NK - 1; k >= 0; k--) begin
            if (ev_d[k]) begin
                ev_code_d = CODE_W'(k);
            end
        end
    end

    // More than one event bit set means at least one must be dropped
    assign ev_multi_d = (ev_d & (ev_d - NK'(1))) != '0;

    // Emission decision: load when the slot is free or being handed off this cycle, otherwise flag the loss
    always_comb begin
        ev_any_d  = (state_q == ST_EVAL) && (ev_d != '0);
        load_d    = ev_any_d && (!val_valid_q || vo.val_ready);
        ovf_set_d = ev_any_d && (!load_d || ev_multi_d);
    end

    // Scan FSM with registered column strobe, debounce commit and output handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DRIVE;
            col_q       <= '0;
            settle_q    <= '0;
            col_drive_q <= COL_FIRST;
            image_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            val_q       <= '0;
            val_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_DRIVE: begin
                    if (settle_q == LAST_SETTLE) begin
                        settle_q <= '0;
                        state_q  <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    image_q <= image_d;
                    state_q <= (col_q == LAST_COL) ? ST_EVAL : ST_NEXT_COL;
                end
                ST_NEXT_COL: begin
                    col_q       <= col_q + 1'b1;
                    col_drive_q <= col_drive_q << 1;
                    state_q     <= ST_DRIVE;
                end
                ST_EVAL: begin
                    cnt_q       <= cnt_d;
                    acc_q       <= acc_d;
                    col_q       <= '0;
                    col_drive_q <= COL_FIRST;
                    state_q     <= ST_DRIVE;
                end
                default: begin
                    state_q <= ST_DRIVE;
                end
            endcase

            if (load_d) begin
                val_q       <= ev_code_d;
                val_valid_q <= 1'b1;
            end else if (val_valid_q && vo.val_ready) begin
                val_valid_q <= 1'b0;
            end

            // A new loss outranks a clear arriving on the same edge
            if (ovf_set_d) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: drives a virtual key matrix and compares every cycle with a frame-level model.
// Latency: model predicts outputs one edge ahead and compares #1 after each rising edge.
// Backpressure: val_ready is driven fixed per scenario or randomized per cycle.
module tb_keypad_scan_encoder;

    localparam int NC     = 4;
    localparam int NR     = 3;
    localparam int NK     = NC * NR;
    localparam int DF     = 3;
    localparam int PER    = 3 + 2;
    localparam int FRAME  = NC * PER;

    logic          clk;
    logic          rst;
    logic [NC-1:0] col_drive;
    logic [NR-1:0] row_sense;
    logic          overflow;
    logic          overflow_clr;
    logic [NK-1:0] keys;

    keypad_scan_encoder_if #(.CODE_W(4)) vif ();

    keypad_scan_encoder #(
        .NUM_COLS        (NC),
        .NUM_ROWS        (NR),
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_FRAMES (DF),
        .CODE_W          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_drive    (col_drive),
        .row_sense    (row_sense),
        .vo           (vif),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a pressed key shorts its column strobe onto its row
    always_comb begin
        row_sense = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (keys[r*NC + c] && col_drive[c]) row_sense[r] = 1'b1;
            end
        end
    end

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: position in frame, consecutive-pressed-frame run length per key, output slot
    int mp;
    int run [NK];
    int mval;
    bit mvalid;
    bit movf;
    bit rand_mode;
    int hs_cnt;
    int hs_val;

    task automatic model_reset();
        mp     = 0;
        mval   = 0;
        mvalid = 1'b0;
        movf   = 1'b0;
        for (int k = 0; k < NK; k++) run[k] = 0;
    endtask

    task automatic tick();
        int  nev;
        int  first;
        bit  loaded;
        bit  ovf_set;
        if (rand_mode) begin
            vif.val_ready = ($urandom_range(0, 3) != 0);
            overflow_clr  = ($urandom_range(0, 15) == 0);
        end
        if (vif.val_valid && vif.val_ready) begin
            hs_cnt++;
            hs_val = int'(vif.val);
        end
        loaded  = 1'b0;
        ovf_set = 1'b0;
        if (mp == FRAME - 1) begin
            nev   = 0;
            first = -1;
            for (int k = 0; k < NK; k++) begin
                if (keys[k]) begin
                    run[k]++;
                    if (run[k] == DF) begin
                        nev++;
                        if (first < 0) first = k;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            if (nev > 0) begin
                if (!mvalid || vif.val_ready) begin
                    mval   = first;
                    mvalid = 1'b1;
                    loaded = 1'b1;
                    if (nev > 1) ovf_set = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        if (!loaded && mvalid && vif.val_ready) mvalid = 1'b0;
        if (ovf_set) movf = 1'b1;
        else if (overflow_clr) movf = 1'b0;
        mp = (mp + 1) % FRAME;
        @(posedge clk);
        #1;
        chk("col_drive", 32'(col_drive), 32'(1 << (mp / PER)));
        chk("val_valid", 32'(vif.val_valid), 32'(mvalid));
        chk("val", 32'(vif.val), 32'(mval));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic finish_frame();
        while (mp != 0) tick();
    endtask

    task automatic run_frames(input int n, input logic [NK-1:0] k);
        finish_frame();
        for (int i = 0; i < n; i++) begin
            keys = k;
            do tick(); while (mp != 0);
        end
    endtask

    function automatic logic [NK-1:0] key(input int k);
        logic [NK-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    logic [NK-1:0] rk;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        hs_cnt           = 0;
        hs_val           = -1;
        rand_mode        = 1'b0;
        rst              = 1'b1;
        keys             = '0;
        overflow_clr     = 1'b0;
        vif.val_ready    = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col_drive", 32'(col_drive), 32'h1);
        chk("rst_val", 32'(vif.val), 32'h0);
        chk("rst_val_valid", 32'(vif.val_valid), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle frames: column walk only
        vif.val_ready = 1'b1;
        run_frames(2, '0);

        // Key 6 (row1,col2) held: one code at the end of frame 3, none after
        hs_cnt = 0;
        run_frames(3, key(6));
        chk("k6_valid_f3", 32'(vif.val_valid), 32'h1);
        chk("k6_val_f3", 32'(vif.val), 32'd6);
        run_frames(2, key(6));
        chk("k6_hs_count", 32'(hs_cnt), 32'd1);
        chk("k6_hs_val", 32'(hs_val), 32'd6);

        // Key 1: 2 pressed, 1 released, 3 pressed -> single code after frame 6
        run_frames(1, '0);
        hs_cnt = 0;
        run_frames(2, key(1));
        run_frames(1, '0);
        run_frames(2, key(1));
        chk("k1_no_early", 32'(vif.val_valid), 32'h0);
        run_frames(1, key(1));
        chk("k1_valid_f6", 32'(vif.val_valid), 32'h1);
        chk("k1_val_f6", 32'(vif.val), 32'd1);
        run_frames(1, '0);
        chk("k1_hs_count", 32'(hs_cnt), 32'd1);

        // Keys 3 and 9 together: lowest wins, overflow flagged, then cleared
        run_frames(3, key(3) | key(9));
        chk("dual_val", 32'(vif.val), 32'd3);
        chk("dual_ovf", 32'(overflow), 32'h1);
        keys = '0;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("dual_ovf_clr", 32'(overflow), 32'h0);

        // Stalled consumer: code 5 pending, key 7 dropped, then handshake
        run_frames(1, '0);
        vif.val_ready = 1'b0;
        run_frames(3, key(5));
        run_frames(1, '0);
        run_frames(3, key(7));
        chk("stall_val", 32'(vif.val), 32'd5);
        chk("stall_valid", 32'(vif.val_valid), 32'h1);
        chk("stall_ovf", 32'(overflow), 32'h1);
        vif.val_ready = 1'b1;
        tick();
        chk("stall_release", 32'(vif.val_valid), 32'h0);

        // Randomized key matrix, consumer readiness and overflow clears
        rk = '0;
        rand_mode = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 5) == 0) rk[k] = ~rk[k];
            end
            run_frames(1, rk);
        end
        rand_mode     = 1'b0;
        overflow_clr  = 1'b0;
        vif.val_ready = 1'b1;
        run_frames(1, '0);

        // Asynchronous reset mid-frame with a code pending
        vif.val_ready = 1'b0;
        run_frames(3, key(4));
        chk("pre_rst_valid", 32'(vif.val_valid), 32'h1);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_col_drive", 32'(col_drive), 32'h1);
        chk("arst_val", 32'(vif.val), 32'h0);
        chk("arst_val_valid", 32'(vif.val_valid), 32'h0);
        chk("arst_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vif.val_ready = 1'b1;
        hs_cnt = 0;
        run_frames(2, key(4));
        chk("rearm_early", 32'(vif.val_valid), 32'h0);
        run_frames(1, key(4));
        chk("rearm_valid", 32'(vif.val_valid), 32'h1);
        chk("rearm_val", 32'(vif.val), 32'd4);
        run_frames(1, key(4));
        chk("rearm_hs_count", 32'(hs_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
